// File: rtl/noc_eject_buffer_if.sv
// Delivery channel from the eject buffer to the local consumer.
// The master drives the head flit and the slave answers with ready.
interface noc_eject_if #(
    parameter int FLIT_DATA_WIDTH = 64,
    parameter int VC_BITS         = 1
);
    logic                       valid;
    logic                       ready;
    logic [FLIT_DATA_WIDTH-1:0] data;
    logic [VC_BITS-1:0]         vc;
    logic                       tail;
    logic                       misroute;

    modport master (output valid, data, vc, tail, misroute, input ready);
    modport slave  (input valid, data, vc, tail, misroute, output ready);
endinterface

// File: rtl/noc_eject_buffer.sv
// Router ejection endpoint: per-VC flit FIFOs, round-robin delivery to the local
// consumer, and one registered credit returned per flit consumed.
//
// state   | meaning
// ST_OPEN | arbiter free to pick the next non-empty VC
// ST_HOLD | head offered but not taken; selected VC and outputs frozen
module noc_eject_buffer #(
    parameter int  NUM_VCS             = 2,
    parameter int  FLIT_DATA_WIDTH     = 64,
    parameter int  NUM_USER_RECV_PORTS = 16,
    parameter int  FLIT_BUFFER_DEPTH   = 8,
    localparam int VC_BITS   = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
    localparam int DEST_BITS = $clog2(NUM_USER_RECV_PORTS),
    localparam int FLIT_W    = 2 + FLIT_DATA_WIDTH + DEST_BITS + VC_BITS,
    localparam int CREDIT_W  = 1 + VC_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FLIT_W-1:0]    flit_in,
    output logic [CREDIT_W-1:0]  credit_out,
    input  logic [DEST_BITS-1:0] recvPortID,
    noc_eject_if.master          out,
    output logic [31:0]          rx_flit_cnt,
    output logic [31:0]          rx_pkt_cnt,
    output logic                 err_overflow,
    output logic                 err_misroute
);
    localparam int PTR_W   = (FLIT_BUFFER_DEPTH > 1) ? $clog2(FLIT_BUFFER_DEPTH) : 1;
    localparam int CNT_W   = $clog2(FLIT_BUFFER_DEPTH + 1);
    localparam int ENTRY_W = FLIT_DATA_WIDTH + 2;

    typedef enum logic {ST_OPEN, ST_HOLD} state_t;

    logic                       in_valid;
    logic                       in_tail;
    logic [DEST_BITS-1:0]       in_dest;
    logic [VC_BITS-1:0]         in_vc;
    logic [FLIT_DATA_WIDTH-1:0] in_data;

    logic [ENTRY_W-1:0] mem    [NUM_VCS][FLIT_BUFFER_DEPTH];
    logic [PTR_W-1:0]   wr_ptr [NUM_VCS];
    logic [PTR_W-1:0]   rd_ptr [NUM_VCS];
    logic [CNT_W-1:0]   count  [NUM_VCS];

    logic [VC_BITS-1:0] last_grant;
    logic [VC_BITS-1:0] hold_vc;
    logic [VC_BITS-1:0] arb_vc;
    logic [VC_BITS-1:0] sel_vc;
    logic               arb_found;
    logic               out_vld;
    logic               vc_ok;
    logic               wr_en;
    logic               overflow;
    logic               misroute;
    logic               pop;
    logic [ENTRY_W-1:0] head;
    state_t             state;
    state_t             state_nxt;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (int'(p) == FLIT_BUFFER_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign {in_valid, in_tail, in_dest, in_vc, in_data} = flit_in;

    // Fullness is judged on the pre-pop count, so a full VC drops even while draining.
    assign vc_ok    = int'(in_vc) < NUM_VCS;
    assign wr_en    = in_valid && vc_ok && (count[in_vc] != CNT_W'(FLIT_BUFFER_DEPTH));
    assign overflow = in_valid && !wr_en;
    assign misroute = in_dest != recvPortID;

    always_comb begin
        int idx;
        idx       = 0;
        arb_found = 1'b0;
        arb_vc    = '0;
        for (int i = 1; i <= NUM_VCS; i++) begin
            idx = (int'(last_grant) + i) % NUM_VCS;
            if (!arb_found && count[idx] != '0) begin
                arb_found = 1'b1;
                arb_vc    = VC_BITS'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_OPEN;
            hold_vc <= '0;
        end else begin
            state <= state_nxt;
            if (out_vld && !out.ready) hold_vc <= sel_vc;
        end
    end

    always_comb begin
        state_nxt = state;
        sel_vc    = arb_vc;
        out_vld   = arb_found;
        case (state)
            ST_OPEN: ;
            ST_HOLD: begin
                sel_vc  = hold_vc;
                out_vld = 1'b1;
            end
            default: ;
        endcase
        pop       = out_vld && out.ready;
        state_nxt = (out_vld && !out.ready) ? ST_HOLD : ST_OPEN;
    end

    assign head         = mem[sel_vc][rd_ptr[sel_vc]];
    assign out.valid    = out_vld;
    assign out.data     = out_vld ? head[FLIT_DATA_WIDTH-1:0] : '0;
    assign out.tail     = out_vld & head[ENTRY_W-1];
    assign out.misroute = out_vld & head[ENTRY_W-2];
    assign out.vc       = out_vld ? sel_vc : '0;

    always_ff @(posedge clk) begin
        if (wr_en) mem[in_vc][wr_ptr[in_vc]] <= {in_tail, misroute, in_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                wr_ptr[v] <= '0;
                rd_ptr[v] <= '0;
                count[v]  <= '0;
            end
            last_grant   <= VC_BITS'(NUM_VCS - 1);
            credit_out   <= '0;
            rx_flit_cnt  <= '0;
            rx_pkt_cnt   <= '0;
            err_overflow <= 1'b0;
            err_misroute <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VCS; v++) begin
                if (wr_en && int'(in_vc) == v) wr_ptr[v] <= next_ptr(wr_ptr[v]);
                if (pop && int'(sel_vc) == v)  rd_ptr[v] <= next_ptr(rd_ptr[v]);
                case ({wr_en && int'(in_vc) == v, pop && int'(sel_vc) == v})
                    2'b10:   count[v] <= count[v] + 1'b1;
                    2'b01:   count[v] <= count[v] - 1'b1;
                    default: ;
                endcase
            end
            if (pop) last_grant <= sel_vc;
            credit_out <= pop ? {1'b1, sel_vc} : '0;
            if (wr_en)            rx_flit_cnt  <= rx_flit_cnt + 32'd1;
            if (wr_en && in_tail) rx_pkt_cnt   <= rx_pkt_cnt + 32'd1;
            if (overflow)         err_overflow <= 1'b1;
            if (wr_en && misroute) err_misroute <= 1'b1;
        end
    end
endmodule

// File: tb/tb_noc_eject_buffer.sv
// Directed bench for noc_eject_buffer: delivery, credits, overflow, arbitration,
// lock, misroute flagging and reset behaviour with hand-computed expectations.
module tb_noc_eject_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic [70:0] flit_in;
    logic [1:0]  credit_out;
    logic [3:0]  recv_id;
    logic [31:0] rx_flit_cnt;
    logic [31:0] rx_pkt_cnt;
    logic        err_overflow;
    logic        err_misroute;
    int          vectors = 0;
    int          miscompares = 0;

    noc_eject_if #(.FLIT_DATA_WIDTH(64), .VC_BITS(1)) out_if ();

    noc_eject_buffer #(
        .NUM_VCS(2), .FLIT_DATA_WIDTH(64), .NUM_USER_RECV_PORTS(16), .FLIT_BUFFER_DEPTH(8)
    ) dut (
        .clk(clk), .rst(rst), .flit_in(flit_in), .credit_out(credit_out),
        .recvPortID(recv_id), .out(out_if), .rx_flit_cnt(rx_flit_cnt),
        .rx_pkt_cnt(rx_pkt_cnt), .err_overflow(err_overflow), .err_misroute(err_misroute)
    );

    always #5 clk = ~clk;

    function automatic logic [70:0] mk_flit(input logic tail, input logic [3:0] dest,
                                            input logic vc, input logic [63:0] data);
        return {1'b1, tail, dest, vc, data};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flit_in = '0;
        out_if.ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flit_in = '0;
        out_if.ready = 1'b0;
        recv_id = 4'd3;
        repeat (2) tick();
        vectors++;
        if ({out_if.valid, out_if.tail, out_if.misroute, out_if.vc} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_status: got %b expected 0000",
                     {out_if.valid, out_if.tail, out_if.misroute, out_if.vc});
        end
        vectors++;
        if (out_if.data !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_data: got %0h expected 0", out_if.data);
        end
        vectors++;
        if ({credit_out, err_overflow, err_misroute} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_credit_err: got %b expected 0000",
                     {credit_out, err_overflow, err_misroute});
        end
        vectors++;
        if ({rx_flit_cnt, rx_pkt_cnt} !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_counters: got %0h/%0h expected 0/0", rx_flit_cnt, rx_pkt_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        out_if.ready = 1'b1;
        flit_in = mk_flit(1'b1, 4'd3, 1'b0, 64'hbeef);
        tick();
        flit_in = '0;
        vectors++;
        if ({out_if.valid, out_if.tail, out_if.misroute, out_if.vc} !== 4'b1100) begin
            miscompares++;
            $display("FAIL single_status: got %b expected 1100",
                     {out_if.valid, out_if.tail, out_if.misroute, out_if.vc});
        end
        vectors++;
        if (out_if.data !== 64'hbeef) begin
            miscompares++;
            $display("FAIL single_data: got %0h expected beef", out_if.data);
        end
        vectors++;
        if (credit_out !== 2'b00) begin
            miscompares++;
            $display("FAIL single_credit_early: got %b expected 00", credit_out);
        end
        tick();
        vectors++;
        if (credit_out !== 2'b10) begin
            miscompares++;
            $display("FAIL single_credit: got %b expected 10", credit_out);
        end
        vectors++;
        if (out_if.valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_drained: got %b expected 0", out_if.valid);
        end
        vectors++;
        if (rx_flit_cnt !== 32'd1 || rx_pkt_cnt !== 32'd1) begin
            miscompares++;
            $display("FAIL single_counters: got %0d/%0d expected 1/1", rx_flit_cnt, rx_pkt_cnt);
        end
        tick();
        vectors++;
        if (credit_out !== 2'b00) begin
            miscompares++;
            $display("FAIL single_credit_pulse: got %b expected 00", credit_out);
        end
    endtask

    task automatic test_overflow();
        logic [63:0] exp_data;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            flit_in = mk_flit(i == 7, 4'd3, 1'b1, 64'h100 + 64'(i));
            tick();
            vectors++;
            if (credit_out !== 2'b00) begin
                miscompares++;
                $display("FAIL ovf_fill_credit[%0d]: got %b expected 00", i, credit_out);
            end
        end
        flit_in = mk_flit(1'b1, 4'd3, 1'b1, 64'h1ff);
        tick();
        flit_in = '0;
        vectors++;
        if (err_overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_err: got %b expected 1", err_overflow);
        end
        vectors++;
        if (rx_flit_cnt !== 32'd8 || rx_pkt_cnt !== 32'd1) begin
            miscompares++;
            $display("FAIL ovf_counters: got %0d/%0d expected 8/1", rx_flit_cnt, rx_pkt_cnt);
        end
        out_if.ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_data = 64'h100 + 64'(i);
            vectors++;
            if (out_if.valid !== 1'b1 || out_if.vc !== 1'b1 || out_if.data !== exp_data
                || out_if.tail !== (i == 7)) begin
                miscompares++;
                $display("FAIL ovf_drain[%0d]: got v=%b vc=%b d=%0h t=%b expected v=1 vc=1 d=%0h t=%b",
                         i, out_if.valid, out_if.vc, out_if.data, out_if.tail, exp_data, (i == 7));
            end
            tick();
            vectors++;
            if (credit_out !== 2'b11) begin
                miscompares++;
                $display("FAIL ovf_credit[%0d]: got %b expected 11", i, credit_out);
            end
        end
        vectors++;
        if (out_if.valid !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_empty: got %b expected 0", out_if.valid);
        end
        tick();
        vectors++;
        if (credit_out !== 2'b00) begin
            miscompares++;
            $display("FAIL ovf_credit_end: got %b expected 00", credit_out);
        end
    endtask

    task automatic test_round_robin();
        logic [63:0] exp_data;
        logic        exp_vc;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            flit_in = mk_flit(1'b0, 4'd3, 1'b0, 64'ha0 + 64'(i));
            tick();
            flit_in = mk_flit(1'b0, 4'd3, 1'b1, 64'hb0 + 64'(i));
            tick();
        end
        flit_in = '0;
        out_if.ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            exp_vc   = (k % 2) == 1;
            exp_data = (exp_vc ? 64'hb0 : 64'ha0) + 64'(k / 2);
            vectors++;
            if (out_if.valid !== 1'b1 || out_if.vc !== exp_vc || out_if.data !== exp_data) begin
                miscompares++;
                $display("FAIL rr[%0d]: got v=%b vc=%b d=%0h expected v=1 vc=%b d=%0h",
                         k, out_if.valid, out_if.vc, out_if.data, exp_vc, exp_data);
            end
            tick();
        end
        vectors++;
        if (out_if.valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rr_empty: got %b expected 0", out_if.valid);
        end
    endtask

    task automatic test_lock();
        do_reset();
        flit_in = mk_flit(1'b1, 4'd3, 1'b1, 64'hc1);
        tick();
        flit_in = mk_flit(1'b1, 4'd3, 1'b0, 64'hc0);
        tick();
        flit_in = '0;
        for (int j = 0; j < 3; j++) begin
            vectors++;
            if (out_if.valid !== 1'b1 || out_if.vc !== 1'b1 || out_if.data !== 64'hc1) begin
                miscompares++;
                $display("FAIL lock_hold[%0d]: got v=%b vc=%b d=%0h expected v=1 vc=1 d=c1",
                         j, out_if.valid, out_if.vc, out_if.data);
            end
            tick();
        end
        out_if.ready = 1'b1;
        tick();
        vectors++;
        if (credit_out !== 2'b11) begin
            miscompares++;
            $display("FAIL lock_credit1: got %b expected 11", credit_out);
        end
        vectors++;
        if (out_if.valid !== 1'b1 || out_if.vc !== 1'b0 || out_if.data !== 64'hc0) begin
            miscompares++;
            $display("FAIL lock_next: got v=%b vc=%b d=%0h expected v=1 vc=0 d=c0",
                     out_if.valid, out_if.vc, out_if.data);
        end
        tick();
        vectors++;
        if (credit_out !== 2'b10) begin
            miscompares++;
            $display("FAIL lock_credit0: got %b expected 10", credit_out);
        end
    endtask

    task automatic test_misroute();
        do_reset();
        out_if.ready = 1'b1;
        flit_in = mk_flit(1'b1, 4'd5, 1'b0, 64'hdead);
        tick();
        flit_in = '0;
        vectors++;
        if (out_if.valid !== 1'b1 || out_if.misroute !== 1'b1 || out_if.data !== 64'hdead) begin
            miscompares++;
            $display("FAIL misroute_head: got v=%b m=%b d=%0h expected v=1 m=1 d=dead",
                     out_if.valid, out_if.misroute, out_if.data);
        end
        vectors++;
        if (err_misroute !== 1'b1 || err_overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL misroute_err: got mis=%b ovf=%b expected mis=1 ovf=0",
                     err_misroute, err_overflow);
        end
        tick();
        vectors++;
        if (credit_out !== 2'b10 || rx_flit_cnt !== 32'd1) begin
            miscompares++;
            $display("FAIL misroute_credit: got c=%b n=%0d expected c=10 n=1", credit_out, rx_flit_cnt);
        end
        tick();
        vectors++;
        if (err_misroute !== 1'b1) begin
            miscompares++;
            $display("FAIL misroute_sticky: got %b expected 1", err_misroute);
        end
    endtask

    task automatic test_full_pop();
        logic [63:0] exp_data;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            flit_in = mk_flit(1'b0, 4'd3, 1'b0, 64'h200 + 64'(i));
            tick();
        end
        out_if.ready = 1'b1;
        flit_in = mk_flit(1'b0, 4'd3, 1'b0, 64'h2ff);
        vectors++;
        if (out_if.data !== 64'h200) begin
            miscompares++;
            $display("FAIL fullpop_head: got %0h expected 200", out_if.data);
        end
        tick();
        flit_in = '0;
        vectors++;
        if (err_overflow !== 1'b1 || rx_flit_cnt !== 32'd8 || credit_out !== 2'b10) begin
            miscompares++;
            $display("FAIL fullpop_drop: got ovf=%b n=%0d c=%b expected ovf=1 n=8 c=10",
                     err_overflow, rx_flit_cnt, credit_out);
        end
        for (int i = 1; i < 8; i++) begin
            exp_data = 64'h200 + 64'(i);
            vectors++;
            if (out_if.valid !== 1'b1 || out_if.data !== exp_data) begin
                miscompares++;
                $display("FAIL fullpop_drain[%0d]: got v=%b d=%0h expected v=1 d=%0h",
                         i, out_if.valid, out_if.data, exp_data);
            end
            tick();
        end
        vectors++;
        if (out_if.valid !== 1'b0) begin
            miscompares++;
            $display("FAIL fullpop_count7: got %b expected 0", out_if.valid);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        flit_in = mk_flit(1'b1, 4'd9, 1'b1, 64'h31);
        tick();
        flit_in = mk_flit(1'b1, 4'd3, 1'b1, 64'h32);
        tick();
        flit_in = mk_flit(1'b1, 4'd3, 1'b0, 64'h33);
        tick();
        flit_in = '0;
        out_if.ready = 1'b1;
        tick();
        out_if.ready = 1'b0;
        vectors++;
        if (credit_out !== 2'b11 || err_misroute !== 1'b1 || out_if.valid !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_pre: got c=%b mis=%b v=%b expected c=11 mis=1 v=1",
                     credit_out, err_misroute, out_if.valid);
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({out_if.valid, out_if.tail, out_if.misroute, out_if.vc, credit_out} !== 6'd0
            || out_if.data !== 64'd0) begin
            miscompares++;
            $display("FAIL midrst_outputs: got v=%b t=%b m=%b vc=%b c=%b d=%0h expected all 0",
                     out_if.valid, out_if.tail, out_if.misroute, out_if.vc, credit_out, out_if.data);
        end
        vectors++;
        if ({rx_flit_cnt, rx_pkt_cnt} !== 64'd0 || {err_overflow, err_misroute} !== 2'b00) begin
            miscompares++;
            $display("FAIL midrst_state: got n=%0d p=%0d ovf=%b mis=%b expected 0 0 0 0",
                     rx_flit_cnt, rx_pkt_cnt, err_overflow, err_misroute);
        end
        tick();
        rst = 1'b0;
        out_if.ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            vectors++;
            if (out_if.valid !== 1'b0 || credit_out !== 2'b00) begin
                miscompares++;
                $display("FAIL midrst_quiet[%0d]: got v=%b c=%b expected v=0 c=00",
                         j, out_if.valid, credit_out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_round_robin();
        test_lock();
        test_misroute();
        test_full_pop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
